filter_frame_packer: RTL and testbench

FILTER_FRAME_PACKER -- requirements
Module: filter_frame_packer

---
 rtl/filter_frame_packer.sv | 193 +++++++++++++++++++
 tb/tb_filter_frame_packer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_frame_packer.sv
// filter_frame_packer
// Collects one filtered sample from each of four channels and emits a frame:
// header {A5, seq, signs}, then the four 16-bit data words.
// Build option: define FRAME_CHECKSUM_EN to append a 16-bit modulo-2^16 sum
// of the header and data words as a sixth word (state CHK).
// All outputs are registers; Frame_Data holds steady while the sink stalls.
module filter_frame_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Ch0_Dataf_ads1,
  input  logic [15:0] Ch1_Dataf_ads1,
  input  logic [15:0] Ch0_Dataf_ads2,
  input  logic [15:0] Ch1_Dataf_ads2,
  input  logic        Ch0_Dataf_en_ads1,
  input  logic        Ch1_Dataf_en_ads1,
  input  logic        Ch0_Dataf_en_ads2,
  input  logic        Ch1_Dataf_en_ads2,
  input  logic        Ch0_Dataf_sign_ads1,
  input  logic        Ch1_Dataf_sign_ads1,
  input  logic        Ch0_Dataf_sign_ads2,
  input  logic        Ch1_Dataf_sign_ads2,
  output logic [15:0] Frame_Data,
  output logic        Frame_Data_en,
  input  logic        Frame_Ready,
  output logic        Frame_sof,
  output logic [3:0]  Overflow
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    D0   = 3'd2,
    D1   = 3'd3,
    D2   = 3'd4,
    D3   = 3'd5,
    CHK  = 3'd6
  } state_t;

  // Channel views in channel order 0..3
  logic [3:0][15:0] in_data_s;
  logic [3:0]       in_en_s;
  logic [3:0]       in_sign_s;

  assign in_data_s = {Ch1_Dataf_ads2, Ch0_Dataf_ads2, Ch1_Dataf_ads1, Ch0_Dataf_ads1};
  assign in_en_s   = {Ch1_Dataf_en_ads2, Ch0_Dataf_en_ads2, Ch1_Dataf_en_ads1, Ch0_Dataf_en_ads1};
  assign in_sign_s = {Ch1_Dataf_sign_ads2, Ch0_Dataf_sign_ads2, Ch1_Dataf_sign_ads1, Ch0_Dataf_sign_ads1};

  state_t           state_q, state_d;
  logic [3:0][16:0] chan_q, chan_d;   // latest {sign, data} per channel
  logic [3:0][16:0] frm_q, frm_d;     // snapshot being emitted
  logic [3:0]       pend_q, pend_d;
  logic [3:0]       seq_q, seq_d;
  logic [3:0]       ovf_q, ovf_d;
  logic [15:0]      data_q, data_d;
  logic             en_q, en_d;
  logic             sof_q, sof_d;
  logic             snap_s;
  logic             accept_s;

  // Word presented in a given state; zero outside a frame
  function automatic logic [15:0] frame_word(input state_t st,
                                             input logic [3:0][16:0] frm,
                                             input logic [3:0] seq);
    logic [15:0] hdr;
    hdr = {8'hA5, seq, frm[3][16], frm[2][16], frm[1][16], frm[0][16]};
    case (st)
      HDR:     frame_word = hdr;
      D0:      frame_word = frm[0][15:0];
      D1:      frame_word = frm[1][15:0];
      D2:      frame_word = frm[2][15:0];
      D3:      frame_word = frm[3][15:0];
      CHK:     frame_word = hdr + frm[0][15:0] + frm[1][15:0]
                          + frm[2][15:0] + frm[3][15:0];
      default: frame_word = 16'h0000;
    endcase
  endfunction

  assign accept_s = en_q & Frame_Ready;

  // Next-state logic: frame sequencing, sample capture, overrun tracking
  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    frm_d   = frm_q;
    pend_d  = pend_q;
    seq_d   = seq_q;
    ovf_d   = ovf_q;
    snap_s  = 1'b0;

    case (state_q)
      IDLE: begin
        if (&pend_q) begin
          snap_s  = 1'b1;
          state_d = HDR;
        end else begin
          state_d = IDLE;
        end
      end
      HDR: begin
        if (accept_s) state_d = D0;
        else          state_d = HDR;
      end
      D0: begin
        if (accept_s) state_d = D1;
        else          state_d = D0;
      end
      D1: begin
        if (accept_s) state_d = D2;
        else          state_d = D1;
      end
      D2: begin
        if (accept_s) state_d = D3;
        else          state_d = D2;
      end
      D3: begin
        if (accept_s) begin
`ifdef FRAME_CHECKSUM_EN
          state_d = CHK;
`else
          state_d = IDLE;
          seq_d   = seq_q + 4'd1;
`endif
        end else begin
          state_d = D3;
        end
      end
      CHK: begin
        if (accept_s) begin
          state_d = IDLE;
          seq_d   = seq_q + 4'd1;
        end else begin
          state_d = CHK;
        end
      end
      default: state_d = IDLE;
    endcase

    // Snapshot takes the old register contents and frees every channel
    if (snap_s) begin
      frm_d  = chan_q;
      pend_d = 4'b0000;
    end else begin
      frm_d  = frm_q;
    end

    // A strobe landing on the snapshot edge starts the next frame, not an overrun
    for (int i = 0; i < 4; i++) begin
      if (in_en_s[i]) begin
        chan_d[i] = {in_sign_s[i], in_data_s[i]};
        pend_d[i] = 1'b1;
        if (pend_q[i] && !snap_s) ovf_d[i] = 1'b1;
        else                      ovf_d[i] = ovf_q[i];
      end else begin
        chan_d[i] = chan_q[i];
      end
    end

    data_d = frame_word(state_d, frm_d, seq_d);
    en_d   = (state_d != IDLE);
    sof_d  = (state_d == HDR);
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      chan_q  <= '0;
      frm_q   <= '0;
      pend_q  <= 4'b0000;
      seq_q   <= 4'd0;
      ovf_q   <= 4'b0000;
      data_q  <= 16'h0000;
      en_q    <= 1'b0;
      sof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      frm_q   <= frm_d;
      pend_q  <= pend_d;
      seq_q   <= seq_d;
      ovf_q   <= ovf_d;
      data_q  <= data_d;
      en_q    <= en_d;
      sof_q   <= sof_d;
    end
  end

  assign Frame_Data    = data_q;
  assign Frame_Data_en = en_q;
  assign Frame_sof     = sof_q;
  assign Overflow      = ovf_q;

endmodule

// File: tb/tb_filter_frame_packer.sv
// Bench for filter_frame_packer: expected frame words are queued as samples
// are strobed in and compared, in order, as the packer's words are accepted.
module tb_filter_frame_packer;

  logic        clk;
  logic        rst;
  logic [15:0] Ch0_Dataf_ads1, Ch1_Dataf_ads1, Ch0_Dataf_ads2, Ch1_Dataf_ads2;
  logic        Ch0_Dataf_en_ads1, Ch1_Dataf_en_ads1, Ch0_Dataf_en_ads2, Ch1_Dataf_en_ads2;
  logic        Ch0_Dataf_sign_ads1, Ch1_Dataf_sign_ads1, Ch0_Dataf_sign_ads2, Ch1_Dataf_sign_ads2;
  logic [15:0] Frame_Data;
  logic        Frame_Data_en;
  logic        Frame_Ready;
  logic        Frame_sof;
  logic [3:0]  Overflow;

  int          checks;
  int          errors;
  logic [16:0] exp_q[$];   // {sof, word}
  logic [3:0]  seq_m;

  filter_frame_packer dut (
    .clk                 (clk),
    .rst                 (rst),
    .Ch0_Dataf_ads1      (Ch0_Dataf_ads1),
    .Ch1_Dataf_ads1      (Ch1_Dataf_ads1),
    .Ch0_Dataf_ads2      (Ch0_Dataf_ads2),
    .Ch1_Dataf_ads2      (Ch1_Dataf_ads2),
    .Ch0_Dataf_en_ads1   (Ch0_Dataf_en_ads1),
    .Ch1_Dataf_en_ads1   (Ch1_Dataf_en_ads1),
    .Ch0_Dataf_en_ads2   (Ch0_Dataf_en_ads2),
    .Ch1_Dataf_en_ads2   (Ch1_Dataf_en_ads2),
    .Ch0_Dataf_sign_ads1 (Ch0_Dataf_sign_ads1),
    .Ch1_Dataf_sign_ads1 (Ch1_Dataf_sign_ads1),
    .Ch0_Dataf_sign_ads2 (Ch0_Dataf_sign_ads2),
    .Ch1_Dataf_sign_ads2 (Ch1_Dataf_sign_ads2),
    .Frame_Data          (Frame_Data),
    .Frame_Data_en       (Frame_Data_en),
    .Frame_Ready         (Frame_Ready),
    .Frame_sof           (Frame_sof),
    .Overflow            (Overflow)
  );

  // 50 MHz clock
  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, act, exp);
    end
  endtask

  // Compare each accepted word against the head of the scoreboard
  always @(negedge clk) begin
    if (Frame_Data_en && Frame_Ready) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_word", {16'h0, Frame_Data}, 32'hFFFF_FFFF);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        check_eq("word", {16'h0, Frame_Data}, {16'h0, e[15:0]});
        check_eq("sof", {31'h0, Frame_sof}, {31'h0, e[16]});
      end
    end
  end

  task automatic set_ch(input int ch, input logic [15:0] d, input logic s);
    case (ch)
      0: begin Ch0_Dataf_en_ads1 = 1'b1; Ch0_Dataf_ads1 = d; Ch0_Dataf_sign_ads1 = s; end
      1: begin Ch1_Dataf_en_ads1 = 1'b1; Ch1_Dataf_ads1 = d; Ch1_Dataf_sign_ads1 = s; end
      2: begin Ch0_Dataf_en_ads2 = 1'b1; Ch0_Dataf_ads2 = d; Ch0_Dataf_sign_ads2 = s; end
      default: begin Ch1_Dataf_en_ads2 = 1'b1; Ch1_Dataf_ads2 = d; Ch1_Dataf_sign_ads2 = s; end
    endcase
  endtask

  task automatic clear_en();
    Ch0_Dataf_en_ads1 = 1'b0;
    Ch1_Dataf_en_ads1 = 1'b0;
    Ch0_Dataf_en_ads2 = 1'b0;
    Ch1_Dataf_en_ads2 = 1'b0;
  endtask

  // One-cycle strobe; returns just after the edge that sampled it
  task automatic strobe(input int ch, input logic [15:0] d, input logic s);
    @(posedge clk); #1;
    set_ch(ch, d, s);
    @(posedge clk); #1;
    clear_en();
  endtask

  // Expected words of one frame, built independently of the design
  task automatic push_frame(input logic [15:0] d0, d1, d2, d3, input logic [3:0] s);
    logic [15:0] hdr;
    logic [15:0] sum;
    hdr = {8'hA5, seq_m, s[3], s[2], s[1], s[0]};
    exp_q.push_back({1'b1, hdr});
    exp_q.push_back({1'b0, d0});
    exp_q.push_back({1'b0, d1});
    exp_q.push_back({1'b0, d2});
    exp_q.push_back({1'b0, d3});
    sum = hdr + d0 + d1 + d2 + d3;
`ifdef FRAME_CHECKSUM_EN
    exp_q.push_back({1'b0, sum});
`endif
    seq_m = seq_m + 4'd1;
  endtask

  // Wait until every expected word is consumed and the packer is idle
  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || Frame_Data_en) && n < 400) begin
      @(posedge clk); #2;
      n++;
    end
    check_eq("drain", exp_q.size(), 32'd0);
  endtask

  initial begin
    logic [15:0] d [4];
    logic [3:0]  s;
    checks = 0;
    errors = 0;
    seq_m  = 4'd0;
    rst    = 1'b0;
    Frame_Ready = 1'b1;
    clear_en();
    Ch0_Dataf_ads1 = 16'h0; Ch1_Dataf_ads1 = 16'h0; Ch0_Dataf_ads2 = 16'h0; Ch1_Dataf_ads2 = 16'h0;
    Ch0_Dataf_sign_ads1 = 1'b0; Ch1_Dataf_sign_ads1 = 1'b0;
    Ch0_Dataf_sign_ads2 = 1'b0; Ch1_Dataf_sign_ads2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_data", {16'h0, Frame_Data}, 32'h0);
    check_eq("rst_en", {31'h0, Frame_Data_en}, 32'h0);
    check_eq("rst_sof", {31'h0, Frame_sof}, 32'h0);
    check_eq("rst_ovf", {28'h0, Overflow}, 32'h0);
    rst = 1'b1;

    // Basic frame: A50A, 1, 2, 3, 4 plus latency of two edges
    strobe(0, 16'd1, 1'b0);
    strobe(1, 16'd2, 1'b1);
    strobe(2, 16'd3, 1'b0);
    push_frame(16'd1, 16'd2, 16'd3, 16'd4, 4'b1010);
    strobe(3, 16'd4, 1'b1);
    check_eq("lat_en_early", {31'h0, Frame_Data_en}, 32'h0);
    @(posedge clk); #1;
    check_eq("lat_en", {31'h0, Frame_Data_en}, 32'h1);
    check_eq("hdr_word", {16'h0, Frame_Data}, 32'h0000_A50A);
    wait_drain();
    check_eq("ovf_clean", {28'h0, Overflow}, 32'h0);

    // Strobe coinciding with the snapshot edge carries over, no overrun
    strobe(0, 16'h0010, 1'b0);
    strobe(1, 16'h0011, 1'b0);
    strobe(2, 16'h0012, 1'b1);
    push_frame(16'h0010, 16'h0011, 16'h0012, 16'h0013, 4'b0100);
    @(posedge clk); #1;
    set_ch(3, 16'h0013, 1'b0);
    @(posedge clk); #1;
    clear_en();
    set_ch(0, 16'h0020, 1'b1);
    @(posedge clk); #1;
    clear_en();
    strobe(1, 16'h0021, 1'b0);
    strobe(2, 16'h0022, 1'b0);
    push_frame(16'h0020, 16'h0021, 16'h0022, 16'h0023, 4'b1001);
    strobe(3, 16'h0023, 1'b1);
    wait_drain();
    check_eq("ovf_snap_edge", {28'h0, Overflow}, 32'h0);

    // Sink stalls five cycles in D1
    Frame_Ready = 1'b0;
    strobe(0, 16'd1, 1'b0);
    strobe(1, 16'd2, 1'b0);
    strobe(2, 16'd3, 1'b0);
    push_frame(16'd1, 16'd2, 16'd3, 16'd4, 4'b0000);
    strobe(3, 16'd4, 1'b0);
    @(posedge clk); #1;
    Frame_Ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    Frame_Ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("stall_data", {16'h0, Frame_Data}, 32'h0000_0002);
      check_eq("stall_en", {31'h0, Frame_Data_en}, 32'h1);
    end
    @(posedge clk); #1;
    Frame_Ready = 1'b1;
    wait_drain();

    // Double strobe on channel 2 before channel 3
    strobe(0, 16'd1, 1'b0);
    strobe(1, 16'd2, 1'b0);
    strobe(2, 16'd5, 1'b0);
    strobe(2, 16'd7, 1'b0);
    push_frame(16'd1, 16'd2, 16'd7, 16'd4, 4'b0000);
    strobe(3, 16'd4, 1'b0);
    wait_drain();
    check_eq("ovf_ch2", {28'h0, Overflow}, 32'h0000_0004);

    // Reset in the middle of D2
    Frame_Ready = 1'b0;
    strobe(0, 16'h0101, 1'b0);
    strobe(1, 16'h0102, 1'b0);
    strobe(2, 16'h0103, 1'b0);
    push_frame(16'h0101, 16'h0102, 16'h0103, 16'h0104, 4'b0000);
    strobe(3, 16'h0104, 1'b0);
    @(posedge clk); #1;
    Frame_Ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    Frame_Ready = 1'b0;
    check_eq("pre_rst_d2", {16'h0, Frame_Data}, 32'h0000_0103);
    #4;
    rst = 1'b0;
    #1;
    check_eq("arst_data", {16'h0, Frame_Data}, 32'h0);
    check_eq("arst_en", {31'h0, Frame_Data_en}, 32'h0);
    check_eq("arst_ovf", {28'h0, Overflow}, 32'h0);
    exp_q.delete();
    seq_m = 4'd0;
    @(posedge clk); #1;
    rst = 1'b1;
    Frame_Ready = 1'b1;
    strobe(0, 16'h0201, 1'b0);
    strobe(1, 16'h0202, 1'b0);
    strobe(2, 16'h0203, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check_eq("no_partial", {31'h0, Frame_Data_en}, 32'h0);

    // Seventeen frames: header seq runs 0..15 then wraps to 0
    for (int f = 0; f < 17; f++) begin
      for (int c = 0; c < 4; c++) d[c] = 16'($urandom);
      s = 4'($urandom);
      if (f == 0) d[0] = 16'h0201;
      if (f == 0) d[1] = 16'h0202;
      if (f == 0) d[2] = 16'h0203;
      if (f == 0) s[2:0] = 3'b000;
      if (f != 0) strobe(0, d[0], s[0]);
      if (f != 0) strobe(1, d[1], s[1]);
      if (f != 0) strobe(2, d[2], s[2]);
      push_frame(d[0], d[1], d[2], d[3], s);
      strobe(3, d[3], s[3]);
      @(posedge clk); #1;
      check_eq("seq_field", {28'h0, Frame_Data[7:4]}, f % 16);
      wait_drain();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
